// File: rtl/riscv_instr_loader.sv
// riscv_instr_loader
//
// Loads a program image into the leaf core's instruction memory. A 32-bit
// valid/ready word stream carries a frame of the form
//   header  : [31:24] = MAGIC, [23:0] = start byte address
//   length  : [23:0]  = byte count N ([31:24] ignored)
//   payload : ceil(N/4) words, each unpacked LSB-first into byte writes
// Each payload byte becomes a one-cycle write on the instruction-config port.
// The core is held in reset (core_hold) from the cycle after the header
// until the cycle after load_done.
//
// Ports
//   clk                 in   user clock
//   resetn              in   asynchronous active-low reset
//   din[31:0]           in   stream word
//   val_in              in   din valid
//   ready_upward        out  word accepted when val_in && ready_upward
//                            (combinational from state)
//   instr_config_addr   out  byte address of the current write
//   instr_config_din    out  byte being written
//   instr_config_wr_en  out  one-cycle write strobe per byte
//   core_hold           out  high while a load is in progress
//   load_done           out  one-cycle pulse when a load completes
//   hdr_err             out  one-cycle pulse when a header word is rejected
module riscv_instr_loader #(
    parameter int          ADDR_BITS = 24,
    parameter logic [7:0]  MAGIC     = 8'h5A
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [31:0]          din,
    input  logic                 val_in,
    output logic                 ready_upward,
    output logic [ADDR_BITS-1:0] instr_config_addr,
    output logic [7:0]           instr_config_din,
    output logic                 instr_config_wr_en,
    output logic                 core_hold,
    output logic                 load_done,
    output logic                 hdr_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Datapath registers
    logic [ADDR_BITS-1:0] r_addr;
    logic [31:0]          r_word;
    logic [1:0]           r_idx;
    logic [23:0]          r_rem;

    // Registered outputs
    logic r_wr_en;
    logic r_core_hold;
    logic r_load_done;
    logic r_hdr_err;

    // Next-state values
    logic [ADDR_BITS-1:0] w_addr_nxt;
    logic [31:0]          w_word_nxt;
    logic [1:0]           w_idx_nxt;
    logic [23:0]          w_rem_nxt;
    logic                 w_hdr_err_nxt;
    logic                 w_ready;
    logic                 w_accept;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath-next logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        w_addr_nxt    = r_addr;
        w_word_nxt    = r_word;
        w_idx_nxt     = r_idx;
        w_rem_nxt     = r_rem;
        w_hdr_err_nxt = 1'b0;

        w_ready  = (r_state == S_IDLE) || (r_state == S_LEN) ||
                   (r_state == S_DATA_WAIT);
        w_accept = w_ready && val_in;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (din[31:24] == MAGIC) begin
                        w_addr_nxt   = ADDR_BITS'(din[23:0]);
                        w_next_state = S_LEN;
                    end else begin
                        w_hdr_err_nxt = 1'b1;
                    end
                end
            end

            S_LEN: begin
                if (w_accept) begin
                    w_rem_nxt = din[23:0];
                    if (din[23:0] == 24'd0) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_DATA_WAIT;
                    end
                end
            end

            S_DATA_WAIT: begin
                if (w_accept) begin
                    w_word_nxt   = din;
                    w_idx_nxt    = 2'd0;
                    w_next_state = S_EMIT;
                end
            end

            S_EMIT: begin
                // The latched word shifts right one byte per write so the
                // current byte always sits in r_word[7:0]; that keeps
                // instr_config_din a plain register output with no byte mux.
                w_word_nxt = {8'h00, r_word[31:8]};
                w_addr_nxt = r_addr + ADDR_BITS'(1);
                w_rem_nxt  = r_rem - 24'd1;
                w_idx_nxt  = r_idx + 2'd1;
                if (r_rem == 24'd1) begin
                    w_next_state = S_DONE;
                end else if (r_idx == 2'd3) begin
                    w_next_state = S_DATA_WAIT;
                end
            end

            S_DONE: begin
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers. Outputs are derived from the next
    // state so they line up with the cycle the FSM spends in that state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr      <= '0;
            r_word      <= '0;
            r_idx       <= '0;
            r_rem       <= '0;
            r_wr_en     <= 1'b0;
            r_core_hold <= 1'b0;
            r_load_done <= 1'b0;
            r_hdr_err   <= 1'b0;
        end else begin
            r_addr      <= w_addr_nxt;
            r_word      <= w_word_nxt;
            r_idx       <= w_idx_nxt;
            r_rem       <= w_rem_nxt;
            r_wr_en     <= (w_next_state == S_EMIT);
            r_core_hold <= (w_next_state != S_IDLE);
            r_load_done <= (w_next_state == S_DONE);
            r_hdr_err   <= w_hdr_err_nxt;
        end
    end

    assign ready_upward       = w_ready;
    assign instr_config_addr  = r_addr;
    assign instr_config_din   = r_word[7:0];
    assign instr_config_wr_en = r_wr_en;
    assign core_hold          = r_core_hold;
    assign load_done          = r_load_done;
    assign hdr_err            = r_hdr_err;

endmodule

// File: tb/tb_riscv_instr_loader.sv
module tb_riscv_instr_loader;

    localparam logic [7:0] MAGIC = 8'h5A;

    logic        clk;
    logic        resetn;
    logic [31:0] din;
    logic        val_in;
    logic        ready_upward;
    logic [23:0] instr_config_addr;
    logic [7:0]  instr_config_din;
    logic        instr_config_wr_en;
    logic        core_hold;
    logic        load_done;
    logic        hdr_err;

    riscv_instr_loader #(
        .ADDR_BITS (24),
        .MAGIC     (8'h5A)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .din                (din),
        .val_in             (val_in),
        .ready_upward       (ready_upward),
        .instr_config_addr  (instr_config_addr),
        .instr_config_din   (instr_config_din),
        .instr_config_wr_en (instr_config_wr_en),
        .core_hold          (core_hold),
        .load_done          (load_done),
        .hdr_err            (hdr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Cycle counter and output monitor (sampled on the falling edge)
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] a;
        logic [7:0]  d;
        int          c;
    } wr_t;

    wr_t  wr_q[$];
    int   done_q[$];
    logic done_hold[$];
    int   hdr_cnt = 0;

    always @(negedge clk) begin
        if (resetn) begin
            if (instr_config_wr_en) wr_q.push_back('{instr_config_addr, instr_config_din, cyc});
            if (load_done) begin
                done_q.push_back(cyc);
                done_hold.push_back(core_hold);
            end
            if (hdr_err) hdr_cnt++;
        end
    end

    logic [31:0] words [0:7];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Present one word, optionally after a random idle gap, and return in
    // the cycle after it was accepted.
    task automatic send_word(input logic [31:0] w, input int gmax);
        int n;
        int g;
        g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
        val_in = 1'b0;
        repeat (g) step();
        din    = w;
        val_in = 1'b1;
        n = 0;
        while (!ready_upward && n < 20) begin
            step();
            n++;
        end
        chk("ready_wait", {31'd0, ready_upward}, 32'd1);
        step();
        val_in = 1'b0;
    endtask

    // One full frame checked against the byte-level model:
    // byte i goes to (start+i) mod 2^24 with value words[i/4] >> 8*(i%4).
    task automatic run_frame(input logic [23:0] start, input int n, input int gmax,
                             input bit spacing);
        int          lc;
        int          k;
        int          hb;
        logic [23:0] ea;
        logic [7:0]  ed;
        logic [31:0] w;
        wr_q.delete();
        done_q.delete();
        done_hold.delete();
        hb = hdr_cnt;

        send_word({MAGIC, start}, gmax);
        chk("hold_after_hdr", {31'd0, core_hold}, 32'd1);
        send_word({8'($urandom), 24'(n)}, gmax);
        lc = cyc;
        for (int i = 0; i < (n + 3) / 4; i++) send_word(words[i], gmax);

        k = 0;
        while (done_q.size() == 0 && k < 100) begin
            step();
            k++;
        end
        chk("done_seen", done_q.size(), 1);
        chk("wr_count", wr_q.size(), n);
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            ea = start + 24'(i);
            w  = words[i / 4];
            ed = 8'(w >> (8 * (i % 4)));
            chk($sformatf("wr_addr[%0d]", i), {8'd0, wr_q[i].a}, {8'd0, ea});
            chk($sformatf("wr_data[%0d]", i), {24'd0, wr_q[i].d}, {24'd0, ed});
            if (spacing) chk($sformatf("wr_cyc[%0d]", i), wr_q[i].c, lc + 1 + i + i / 4);
        end
        if (done_q.size() > 0) begin
            if (n == 0) chk("done_cyc", done_q[0], lc);
            else if (wr_q.size() > 0) chk("done_cyc", done_q[0], wr_q[wr_q.size()-1].c + 1);
            chk("hold_at_done", {31'd0, done_hold[0]}, 32'd1);
        end
        step();
        chk("hold_idle", {31'd0, core_hold}, 32'd0);
        chk("ready_idle", {31'd0, ready_upward}, 32'd1);
        chk("done_single", done_q.size(), 1);
        chk("no_hdr_err", hdr_cnt - hb, 0);
    endtask

    task automatic rand_words();
        for (int i = 0; i < 8; i++) words[i] = $urandom;
    endtask

    initial begin
        logic [31:0] bw;
        int k;
        resetn = 1'b0;
        val_in = 1'b0;
        din    = '0;
        #2;
        chk("rst_ready", {31'd0, ready_upward}, 32'd1);
        chk("rst_addr", {8'd0, instr_config_addr}, 32'd0);
        chk("rst_din", {24'd0, instr_config_din}, 32'd0);
        chk("rst_wr_en", {31'd0, instr_config_wr_en}, 32'd0);
        chk("rst_hold", {31'd0, core_hold}, 32'd0);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        chk("rst_hdr_err", {31'd0, hdr_err}, 32'd0);
        step();
        step();
        resetn = 1'b1;
        step();

        // Basic 8-byte load, gap-free timing
        words[0] = 32'h44332211;
        words[1] = 32'h88776655;
        run_frame(24'h000100, 8, 0, 1'b1);

        // Partial final word
        words[0] = 32'hDDCCBBAA;
        words[1] = 32'h000000EE;
        run_frame(24'h002000, 5, 0, 1'b1);

        // Rejected headers, then a valid frame
        for (int r = 0; r < 3; r++) begin
            k = hdr_cnt;
            wr_q.delete();
            if (r == 0) bw = 32'h12000000;
            else begin
                bw = $urandom;
                if (bw[31:24] == MAGIC) bw[31:24] = 8'h00;
            end
            send_word(bw, 0);
            chk("hdr_err_pulse", {31'd0, hdr_err}, 32'd1);
            chk("hdr_err_hold", {31'd0, core_hold}, 32'd0);
            step();
            chk("hdr_err_once", hdr_cnt - k, 1);
            chk("hdr_err_nowr", wr_q.size(), 0);
            chk("hdr_err_ready", {31'd0, ready_upward}, 32'd1);
        end
        rand_words();
        run_frame(24'($urandom), 7, 0, 1'b1);

        // Address wrap
        rand_words();
        run_frame(24'hFFFFFE, 4, 0, 1'b1);

        // Zero length
        run_frame(24'h000055, 0, 0, 1'b0);

        // Same 16-byte image with and without stream gaps
        rand_words();
        run_frame(24'h00A000, 16, 0, 1'b1);
        run_frame(24'h00A000, 16, 3, 1'b0);

        // Random frames with random gaps
        for (int r = 0; r < 6; r++) begin
            rand_words();
            run_frame(24'($urandom), int'($urandom_range(1, 32)), 2, 1'b0);
        end

        // Reset during EMIT aborts the load
        wr_q.delete();
        done_q.delete();
        send_word({MAGIC, 24'h000300}, 0);
        send_word(32'd16, 0);
        send_word(32'hCAFEF00D, 0);
        chk("emit_wr_en", {31'd0, instr_config_wr_en}, 32'd1);
        step();
        resetn = 1'b0;
        #1;
        chk("abort_wr_en", {31'd0, instr_config_wr_en}, 32'd0);
        chk("abort_hold", {31'd0, core_hold}, 32'd0);
        chk("abort_ready", {31'd0, ready_upward}, 32'd1);
        chk("abort_addr", {8'd0, instr_config_addr}, 32'd0);
        chk("abort_partial", wr_q.size(), 2);
        step();
        resetn = 1'b1;
        repeat (4) step();
        chk("abort_no_done", done_q.size(), 0);
        chk("abort_idle_hold", {31'd0, core_hold}, 32'd0);

        // Recovery after abort
        rand_words();
        run_frame(24'h000400, 9, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
